// File: rtl/med_pkg.sv
// Shared constants and FSM encoding for the 5-tap median window controller.
// Widths come from idx_w() so a one-line frame still gets a 1-bit row index.
package med_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W     = idx_w(DEF_IMG_W);
    localparam int ROW_W     = idx_w(DEF_IMG_H);
    localparam int WIN_SIZE  = 5;
    localparam int PAD_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PADL = 2'd1,
        RUN  = 2'd2,
        PADR = 2'd3
    } state_t;

endpackage

// File: rtl/win_pos_cnt.sv
// Input column / frame row counters with wrap.
// Also decodes end-of-line and end-of-frame from the per-line shift count.
module win_pos_cnt
    import med_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      col_inc,
    input  logic                      row_inc,
    input  logic [CNT_W-1:0]          shift_cnt,
    output logic [idx_w(IMG_H)-1:0]   row,
    output logic                      col_last,
    output logic                      eol_hit,
    output logic                      eof_hit
);

    localparam int COL_BITS = idx_w(IMG_W);
    localparam int ROW_BITS = idx_w(IMG_H);

    logic [COL_BITS-1:0] col;
    logic                row_last;

    assign col_last = (col == COL_BITS'(IMG_W - 1));
    assign row_last = (row == ROW_BITS'(IMG_H - 1));

    // The last shift of a line carries the window centred on column IMG_W-1.
    assign eol_hit = (shift_cnt == CNT_W'(IMG_W + WIN_SIZE - 2));
    assign eof_hit = eol_hit && row_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else begin
            if (col_inc) begin
                col <= col_last ? '0 : col + 1'b1;
            end
            if (row_inc) begin
                row <= row_last ? '0 : row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/med_win_ctrl.sv
// Feeds an external 5-tap shift register with edge-replicated raster pixels
// and flags when its taps hold a complete median window.
module med_win_ctrl
    import med_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [DATA_W-1:0]         s_data,
    output logic                      s_ready,
    output logic                      shr_en,
    output logic [DATA_W-1:0]         shr_din,
    output logic                      win_valid,
    input  logic                      m_ready,
    output logic [idx_w(IMG_W)-1:0]   win_col,
    output logic [idx_w(IMG_H)-1:0]   win_row,
    output logic                      eol,
    output logic                      eof,
    output logic                      busy
);

    localparam int COL_BITS = idx_w(IMG_W);
    localparam int ROW_BITS = idx_w(IMG_H);
    localparam int CNT_W    = $clog2(IMG_W + WIN_SIZE - 1);
    localparam int PAD_W    = 2;

    state_t              state;
    logic [DATA_W-1:0]   hold;
    logic [PAD_W-1:0]    pad_cnt;
    logic [CNT_W-1:0]    shift_cnt;
    logic [ROW_BITS-1:0] row;
    logic                adv, padding, accept, win_hit, pad_last;
    logic                col_last, eol_hit, eof_hit;

    assign adv     = !win_valid || m_ready;
    assign padding = (state == PADL) || (state == PADR);

    // rst gates the handshake so nothing is offered or shifted while held in reset.
    assign s_ready  = rst && adv && !padding;
    assign shr_en   = rst && adv && (padding || s_valid);
    assign shr_din  = padding ? hold : s_data;
    assign accept   = s_valid && s_ready;
    assign win_hit  = shr_en && (shift_cnt >= CNT_W'(WIN_SIZE - 1));
    assign pad_last = (pad_cnt == PAD_W'(1));
    assign busy     = (state != IDLE) || win_valid;

    win_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .col_inc   (accept),
        .row_inc   ((state == PADR) && shr_en && pad_last),
        .shift_cnt (shift_cnt),
        .row       (row),
        .col_last  (col_last),
        .eol_hit   (eol_hit),
        .eof_hit   (eof_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold      <= '0;
            pad_cnt   <= '0;
            shift_cnt <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            // Window outputs only move when the current one is consumed or absent.
            if (adv) begin
                win_valid <= win_hit;
                if (win_hit) begin
                    win_col <= COL_BITS'(shift_cnt - CNT_W'(WIN_SIZE - 1));
                    win_row <= row;
                    eol     <= eol_hit;
                    eof     <= eof_hit;
                end
            end

            if (shr_en) begin
                shift_cnt <= shift_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        hold    <= s_data;
                        pad_cnt <= PAD_W'(PAD_DEPTH);
                        state   <= PADL;
                    end
                end
                PADL: begin
                    if (shr_en) begin
                        pad_cnt <= pad_cnt - 1'b1;
                        if (pad_last) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        hold <= s_data;
                        if (col_last) begin
                            pad_cnt <= PAD_W'(PAD_DEPTH);
                            state   <= PADR;
                        end
                    end
                end
                PADR: begin
                    if (shr_en) begin
                        pad_cnt <= pad_cnt - 1'b1;
                        if (pad_last) begin
                            state     <= IDLE;
                            shift_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_med_win_ctrl.sv
// Bench for med_win_ctrl: external 5-tap shift register, replicate-pad window model,
// directed and randomized streams on an 8x2 instance plus a directed 2-pixel-line instance.
module tb_med_win_ctrl;

    localparam int W = 8;
    localparam int H = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready, shr_en, win_valid, m_ready, eol, eof, busy;
    logic [7:0] shr_din;
    logic [2:0] win_col;
    logic [0:0] win_row;

    logic       s_valid_b;
    logic [7:0] s_data_b;
    logic       s_ready_b, shr_en_b, win_valid_b, eol_b, eof_b, busy_b;
    logic       m_ready_b = 1'b1;
    logic [7:0] shr_din_b;
    logic [0:0] win_col_b;
    logic [0:0] win_row_b;

    med_win_ctrl #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .shr_en(shr_en), .shr_din(shr_din), .win_valid(win_valid), .m_ready(m_ready),
        .win_col(win_col), .win_row(win_row), .eol(eol), .eof(eof), .busy(busy)
    );

    med_win_ctrl #(.DATA_W(8), .IMG_W(2), .IMG_H(1)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
        .shr_en(shr_en_b), .shr_din(shr_din_b), .win_valid(win_valid_b), .m_ready(m_ready_b),
        .win_col(win_col_b), .win_row(win_row_b), .eol(eol_b), .eof(eof_b), .busy(busy_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Model state: every accepted pixel since time 0, window index since last reset.
    logic [7:0] pix [1024];
    int nacc = 0, base = 0, wexp = 0, nshift = 0;
    int drv_cnt = 0, stall_cycles = 0, last_take = 0;
    logic [7:0] taps [5];
    logic [7:0] taps_b [5];
    logic [39:0] wb_taps [4];
    logic [1:0]  wb_col_flags [4];
    logic        wb_eof [4];
    int nb = 0, nshift_b = 0;

    function automatic logic [39:0] model_win(input int w);
        int line, col, idx;
        logic [39:0] r;
        line = w / W;
        col  = w % W;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            idx = col - 2 + k;
            if (idx < 0) idx = 0;
            if (idx > W - 1) idx = W - 1;
            r = {r[31:0], pix[(base + line * W + idx) % 1024]};
        end
        return r;
    endfunction

    // Monitor: sampled on the falling edge, well away from the active edge.
    initial begin
        bit prev_stall;
        logic [39:0] ptaps, tp;
        logic [2:0] pcol;
        logic [0:0] prow;
        logic [1:0] pflags;
        int col, row;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                tp = {taps[0], taps[1], taps[2], taps[3], taps[4]};
                if (prev_stall) begin
                    chk("hold_valid", 64'(win_valid), 64'(1));
                    chk("hold_col", 64'(win_col), 64'(pcol));
                    chk("hold_row", 64'(win_row), 64'(prow));
                    chk("hold_flags", 64'({eol, eof}), 64'(pflags));
                    chk("hold_taps", 64'(tp), 64'(ptaps));
                end
                if (s_valid && s_ready) begin
                    pix[nacc % 1024] = s_data;
                    nacc++;
                end
                if (win_valid && m_ready) begin
                    col = wexp % W;
                    row = (wexp / W) % H;
                    chk("win_taps", 64'(tp), 64'(model_win(wexp)));
                    chk("win_col", 64'(win_col), 64'(col));
                    chk("win_row", 64'(win_row), 64'(row));
                    chk("win_eol", 64'(eol), 64'(col == W - 1));
                    chk("win_eof", 64'(eof), 64'(col == W - 1 && row == H - 1));
                    wexp++;
                end
                prev_stall = win_valid && !m_ready;
                if (prev_stall) begin
                    chk("stall_shr_en", 64'(shr_en), 64'(0));
                    chk("stall_s_ready", 64'(s_ready), 64'(0));
                    ptaps  = tp;
                    pcol   = win_col;
                    prow   = win_row;
                    pflags = {eol, eof};
                end
                if (shr_en) begin
                    for (int k = 0; k < 4; k++) taps[k] = taps[k + 1];
                    taps[4] = shr_din;
                    nshift++;
                end
                if (win_valid_b && nb < 4) begin
                    wb_taps[nb]      = {taps_b[0], taps_b[1], taps_b[2], taps_b[3], taps_b[4]};
                    wb_col_flags[nb] = {win_col_b, eol_b};
                    wb_eof[nb]       = eof_b;
                    nb++;
                end
                if (shr_en_b) begin
                    for (int k = 0; k < 4; k++) taps_b[k] = taps_b[k + 1];
                    taps_b[4] = shr_din_b;
                    nshift_b++;
                end
            end
        end
    end

    // Offers npix pixels with pv% valid probability and pm% ready probability.
    task automatic drive(input int npix, input int pv, input int pm, input bit rnd,
                         input int stall_col, input bit wait_idle);
        int target, guard, stall_left;
        bit took, stalled_once;
        logic [7:0] cur;
        target = drv_cnt + npix;
        guard = 0;
        stall_left = 0;
        stalled_once = 1'b0;
        cur = rnd ? 8'($urandom) : 8'(drv_cnt % W + 1);
        while ((drv_cnt < target || (wait_idle && busy)) && guard < 5000) begin
            s_valid = (drv_cnt < target) && (int'($urandom_range(99)) < pv);
            s_data  = cur;
            if (!stalled_once && win_valid && int'(win_col) == stall_col) begin
                stall_left = 5;
                stalled_once = 1'b1;
            end
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
                stall_cycles++;
            end else begin
                m_ready = int'($urandom_range(99)) < pm;
            end
            #2;
            took = s_valid && s_ready;
            guard++;
            if (took) begin
                drv_cnt++;
                if (drv_cnt == target) last_take = guard;
                cur = rnd ? 8'($urandom) : 8'(drv_cnt % W + 1);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (guard >= 5000) chk("timeout", 64'(guard), 64'(0));
    endtask

    initial begin
        int s0, w0, gb;
        bit tk;
        rst = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h55;
        m_ready = 1'b0;
        s_valid_b = 1'b0;
        s_data_b = 8'd0;
        for (int k = 0; k < 5; k++) begin
            taps[k] = '0;
            taps_b[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_shr_en", 64'(shr_en), 64'(0));
        chk("rst_outputs", 64'({win_valid, eol, eof, busy, win_col, win_row}), 64'(0));
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("release_s_ready", 64'(s_ready), 64'(1));
        chk("release_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;

        // Two full lines at full rate: 16 windows, 24 shifts, last pixel on cycle 22.
        s0 = nshift; w0 = wexp;
        drive(2 * W, 100, 100, 1'b0, -1, 1'b1);
        chk("full_rate_last_take", 64'(last_take), 64'(2 * (W + 4) - 2));
        chk("full_rate_shifts", 64'(nshift - s0), 64'(2 * (W + 4)));
        chk("full_rate_windows", 64'(wexp - w0), 64'(2 * W));

        // One line with a 5-cycle back-pressure stall on the col3 window.
        s0 = nshift; w0 = wexp; stall_cycles = 0;
        drive(W, 100, 100, 1'b0, 3, 1'b1);
        chk("stall_cycles", 64'(stall_cycles), 64'(5));
        chk("stall_shifts", 64'(nshift - s0), 64'(W + 4));
        chk("stall_windows", 64'(wexp - w0), 64'(W));

        // Reset after 5 pixels: partial line abandoned, restart at row 0 col 0.
        drive(5, 100, 100, 1'b0, -1, 1'b0);
        rst = 1'b0;
        s_valid = 1'b1;
        #1;
        chk("midrst_s_ready", 64'(s_ready), 64'(0));
        chk("midrst_shr_en", 64'(shr_en), 64'(0));
        chk("midrst_outputs", 64'({win_valid, eol, eof, busy, win_col, win_row}), 64'(0));
        base = nacc; wexp = 0; drv_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
        s0 = nshift; w0 = wexp;
        drive(W, 100, 100, 1'b0, -1, 1'b1);
        chk("after_rst_windows", 64'(wexp - w0), 64'(W));

        // Random valid gaps and back-pressure with random pixel data.
        s0 = nshift; w0 = wexp;
        drive(6 * W, 70, 60, 1'b1, -1, 1'b1);
        chk("rand_windows", 64'(wexp - w0), 64'(6 * W));
        chk("rand_shifts", 64'(nshift - s0), 64'(6 * (W + 4)));

        // Two-pixel line on the narrow instance.
        s_valid_b = 1'b1;
        s_data_b = 8'd10;
        gb = 0;
        while ((s_valid_b || busy_b) && gb < 200) begin
            #2;
            tk = s_valid_b && s_ready_b;
            @(posedge clk);
            #1;
            gb++;
            if (tk) begin
                if (s_data_b == 8'd10) s_data_b = 8'd20;
                else s_valid_b = 1'b0;
            end
        end
        if (gb >= 200) chk("timeout_b", 64'(gb), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("b_windows", 64'(nb), 64'(2));
        chk("b_shifts", 64'(nshift_b), 64'(6));
        chk("b_taps_col0", 64'(wb_taps[0]), 64'(40'h0a0a0a1414));
        chk("b_taps_col1", 64'(wb_taps[1]), 64'(40'h0a0a141414));
        chk("b_col_eol0", 64'(wb_col_flags[0]), 64'(2'b00));
        chk("b_col_eol1", 64'(wb_col_flags[1]), 64'(2'b11));
        chk("b_eof", 64'({wb_eof[0], wb_eof[1]}), 64'(2'b01));
        chk("b_row", 64'(win_row_b), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/med_win_ctrl.md
MED_WIN_CTRL -- requirements
Module: med_win_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, pixel width; IMG_W, default 640, pixels per line (legal range 2 or more); IMG_H, default 480, lines per frame (legal range 1 or more).
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port s_valid  input  1  incoming pixel valid.
REQ-005 Port s_data  input  DATA_W  incoming pixel, raster order.
REQ-006 Port s_ready  output  1  controller accepts s_data this cycle.
REQ-007 Port shr_en  output  1  shift enable to the 5-tap pixel shift register.
REQ-008 Port shr_din  output  DATA_W  value shifted in when shr_en=1.
REQ-009 Port win_valid  output  1  the shift-register taps hold a complete window.
REQ-010 Port m_ready  input  1  downstream median core consumes the window.
REQ-011 Port win_col  output  clog2(IMG_W)  column of the window centre.
REQ-012 Port win_row  output  clog2(IMG_H)  row of the window centre.
REQ-013 Port eol, eof  output  1 each  window is the last of a line or the last of a frame; both are qualified by win_valid.
REQ-014 Port busy  output  1  high when state is not IDLE or win_valid=1.

Function
REQ-015 Advance condition: adv = !win_valid || m_ready; shr_en SHALL be 1 only when adv=1 and a pixel source is available.
REQ-016 FSM states SHALL be IDLE, PADL, RUN and PADR.
REQ-017 IDLE: s_ready=adv.
  - On s_valid && s_ready, shift s_data, copy it to the hold register, set pad_cnt=2, and go to PADL.
REQ-018 PADL: s_ready=0.
  - Each adv cycle shifts the hold register and decrements pad_cnt.
  - At pad_cnt 1->0, go to RUN; if IMG_W=1 were allowed it would go to PADR, but IMG_W is at least 2, so the next state is always RUN.
REQ-019 RUN: s_ready=adv.
  - Each accepted pixel is shifted, updates the hold register and increments the input column.
  - Accepting pixel IMG_W-1 sets pad_cnt=2 and goes to PADR.
REQ-020 PADR: s_ready=0.
  - Each adv cycle shifts the hold register.
  - At pad_cnt 1->0, go to IDLE and increment the row, wrapping IMG_H-1 to 0.
REQ-021 Shifts per line: exactly IMG_W+4 (3 copies of pixel 0, pixels 1..IMG_W-1, then 2 copies of pixel IMG_W-1), giving edge-replicate padding.
REQ-022 A per-line shift counter, 0..IMG_W+3, SHALL be cleared on entry to IDLE.
REQ-023 win_valid is registered: it SHALL be set on the cycle after the shift with counter value 4..IMG_W+3, and cleared on the cycle after a handshake that is not followed by such a shift.
REQ-024 Exactly IMG_W windows per line.
REQ-025 win_col SHALL be the counter value minus 4 for that shift; win_row SHALL be the row of the line being shifted.
REQ-026 eol=1 iff win_col=IMG_W-1; eof=1 iff eol && win_row=IMG_H-1.
REQ-027 While win_valid && !m_ready, the outputs win_valid, win_col, win_row, eol and eof SHALL hold, and shr_en=0.
REQ-028 Full throughput: with s_valid and m_ready both held at 1, one line SHALL complete in IMG_W+4 cycles, with no bubble between lines other than the IDLE accept cycle.
REQ-029 shr_din = s_data in IDLE and RUN, and the hold register in PADL and PADR.
REQ-030 shr_din SHALL be unspecified when shr_en=0.

Reset
REQ-031 On rst=0, asynchronously:
  - state=IDLE, all counters=0, hold=0, pad_cnt=0;
  - outputs shr_en, win_valid, eol, eof and busy =0; win_col, win_row =0.
REQ-032 Reset mid-line or mid-frame SHALL abandon the partial line; the first pixel accepted after release SHALL be row 0, column 0.
REQ-033 s_ready SHALL be 0 while rst=0, and 1 in the first cycle after release (IDLE with adv=1).

Structure
REQ-034 Shared package med_pkg SHALL hold DATA_W, IMG_W and IMG_H defaults, the COL_W and ROW_W clog2 constants, the window size constant 5, the pad depth 2, and the FSM state encoding.
REQ-035 The controller SHALL NOT instantiate the shift register; the top level connects shr_en and shr_din to it.
REQ-036 One sub-module is natural: win_pos_cnt.
  - It holds the column and row counters with wrap, and the eol/eof decode.

Verification
REQ-037 IMG_W=8, IMG_H=2, s_data=1..8, s_valid=1, m_ready=1 -> 8 windows.
  - Taps for col0 = {1,1,1,2,3}.
  - Taps for col7 = {6,7,8,8,8}.
  - eol on col7; 12 shr_en pulses per line.
REQ-038 Same stream, but m_ready=0 for 5 cycles at col3 -> the col3 window holds stable, shr_en=0 and s_ready=0 throughout; no window is lost or duplicated.
REQ-039 IMG_H=2, two lines sent back-to-back -> win_row goes 0 then 1; eof=1 only with row1 col7; win_row wraps to 0 for the next frame.
REQ-040 rst pulsed low after 5 pixels of a line -> all outputs 0 during reset; the next line restarts at row 0, col 0, with the first window taps replicating the new pixel 0.
REQ-041 IMG_W=2, pixels {10,20} -> 2 windows: {10,10,10,20,20} at col0 and {10,10,20,20,20} at col1.
REQ-042 Random s_valid gaps combined with random m_ready -> scoreboard against a software 5-tap replicate-pad model; exact window count; windows arrive in order.
